// File: rtl/mem_arbiter.sv
// Two-port (IFU fetch / LSU data) arbiter onto one memory port, one outstanding transaction, WAIT timeout.
// Optional macro ARB_ROUND_ROBIN_EN: alternate winners on contention; default is fixed LSU priority.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_t      state_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        own_lsu_q;
  logic        mem_req_valid_q, mem_wen_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_wmask_q;
  logic        ifu_rsp_valid_q, lsu_rsp_valid_q, err_q, busy_q;
  logic [31:0] ifu_rdata_q, lsu_rdata_q;

  logic        prefer_lsu, pick_ifu, idle_ok, ifu_acc, lsu_acc, finish, timed_out;
  logic [31:0] rsp_dat;

`ifdef ARB_ROUND_ROBIN_EN
  // Set after an IFU grant, cleared after an LSU grant: the last winner loses the next tie.
  logic rr_q;
  assign prefer_lsu = rr_q;
`else
  assign prefer_lsu = 1'b1;
`endif

  assign idle_ok       = (state_q == S_IDLE) && !rst;
  assign pick_ifu      = ifu_req_valid && (!lsu_req_valid || !prefer_lsu);
  assign ifu_req_ready = idle_ok && pick_ifu;
  assign lsu_req_ready = idle_ok && !pick_ifu;
  assign ifu_acc       = ifu_req_ready && ifu_req_valid;
  assign lsu_acc       = lsu_req_ready && lsu_req_valid;

  // A response arriving in the same cycle the limit is reached takes precedence over the timeout.
  assign cnt_d     = cnt_q + 8'd1;
  assign timed_out = !mem_rsp_valid && (cnt_d == TIMEOUT_LIM);
  assign finish    = (state_q == S_WAIT) && (mem_rsp_valid || timed_out);
  assign rsp_dat   = (mem_rsp_valid && !mem_wen_q) ? mem_rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= 8'd0;
      own_lsu_q       <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_wen_q       <= 1'b0;
      mem_addr_q      <= 32'd0;
      mem_wdata_q     <= 32'd0;
      mem_wmask_q     <= 4'd0;
      ifu_rsp_valid_q <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      ifu_rdata_q     <= 32'd0;
      lsu_rdata_q     <= 32'd0;
      err_q           <= 1'b0;
      busy_q          <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q            <= 1'b1;
`endif
    end else begin
      ifu_rsp_valid_q <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      err_q           <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ifu_acc || lsu_acc) begin
            state_q         <= S_REQ;
            busy_q          <= 1'b1;
            mem_req_valid_q <= 1'b1;
            own_lsu_q       <= lsu_acc;
            mem_addr_q      <= lsu_acc ? lsu_addr : ifu_addr;
            mem_wen_q       <= lsu_acc && lsu_wen;
            mem_wdata_q     <= lsu_acc ? lsu_wdata : 32'd0;
            mem_wmask_q     <= lsu_acc ? lsu_wmask : 4'd0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q            <= ifu_acc;
`endif
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state_q         <= S_WAIT;
            mem_req_valid_q <= 1'b0;
            cnt_q           <= 8'd0;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (finish) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            err_q   <= timed_out;
            if (own_lsu_q) begin
              lsu_rsp_valid_q <= 1'b1;
              lsu_rdata_q     <= rsp_dat;
            end else begin
              ifu_rsp_valid_q <= 1'b1;
              ifu_rdata_q     <= rsp_dat;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
  assign ifu_rsp_valid = ifu_rsp_valid_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rsp_valid = lsu_rsp_valid_q;
  assign lsu_rdata     = lsu_rdata_q;
  assign busy          = busy_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model of arbitration, latency and timeout.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid = 1'b0, ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid = 1'b0, lsu_req_ready;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic        lsu_wen = 1'b0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy, err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: who wins a tie next, and the last delivered rdata per requester.
  bit          pref_lsu = 1'b1;
  logic [31:0] ifu_rd_m = '0, lsu_rd_m = '0;

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ifu_rdy"}, ifu_req_ready, 0);
    check_eq({tag, "_lsu_rdy"}, lsu_req_ready, 0);
    check_eq({tag, "_mreqv"},   mem_req_valid, 0);
    check_eq({tag, "_maddr"},   mem_addr, 0);
    check_eq({tag, "_mwen"},    mem_wen, 0);
    check_eq({tag, "_mwdata"},  mem_wdata, 0);
    check_eq({tag, "_mwmask"},  mem_wmask, 0);
    check_eq({tag, "_busy"},    busy, 0);
    check_eq({tag, "_err"},     err_timeout, 0);
    check_eq({tag, "_irspv"},   ifu_rsp_valid, 0);
    check_eq({tag, "_lrspv"},   lsu_rsp_valid, 0);
    check_eq({tag, "_irdata"},  ifu_rdata, 0);
    check_eq({tag, "_lrdata"},  lsu_rdata, 0);
  endtask

  // Called in an IDLE cycle just after a negedge; returns in the response cycle (IDLE again).
  task automatic do_txn(input bit iv, input bit lv, input bit wen,
                        input logic [31:0] ia, input logic [31:0] la,
                        input logic [31:0] wd, input logic [3:0] wm, input logic [31:0] rd,
                        input int rdy_dly, input int rsp_dly, output bit got_lsu);
    bit          exp_lsu, timed;
    logic [31:0] e_addr, e_rd;
    int          w;
    exp_lsu = lv && (!iv || pref_lsu);
    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_addr = la; lsu_wen = wen; lsu_wdata = wd; lsu_wmask = wm;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    #1;
    check_eq("grant_ifu", ifu_req_ready, !exp_lsu);
    check_eq("grant_lsu", lsu_req_ready, exp_lsu);
    check_eq("idle_busy", busy, 0);
    got_lsu = lsu_req_ready;
`ifdef ARB_ROUND_ROBIN_EN
    pref_lsu = !exp_lsu;
`endif
    e_addr = exp_lsu ? la : ia;

    @(negedge clk);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_rsp_valid = 1'($urandom_range(0, 1)); mem_req_ready = (rdy_dly == 0);
    #1;
    check_eq("req_valid", mem_req_valid, 1);
    check_eq("req_addr", mem_addr, e_addr);
    check_eq("req_wen", mem_wen, exp_lsu ? 32'(wen) : 32'd0);
    check_eq("req_wmask", mem_wmask, exp_lsu ? 32'(wm) : 32'd0);
    if (exp_lsu) check_eq("req_wdata", mem_wdata, wd);
    check_eq("req_busy", busy, 1);
    check_eq("req_rdy", {ifu_req_ready, lsu_req_ready}, 0);
    check_eq("req_rspv", {ifu_rsp_valid, lsu_rsp_valid}, 0);
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      mem_rsp_valid = 1'($urandom_range(0, 1)); mem_req_ready = (i == rdy_dly - 1);
      #1;
      check_eq("hold_valid", mem_req_valid, 1);
      check_eq("hold_addr", mem_addr, e_addr);
      check_eq("hold_rdy", {ifu_req_ready, lsu_req_ready}, 0);
      check_eq("hold_busy", busy, 1);
    end

    @(negedge clk);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    w = 0;
    forever begin
      #1;
      check_eq("wait_valid", mem_req_valid, 0);
      check_eq("wait_busy", busy, 1);
      check_eq("wait_out", {ifu_rsp_valid, lsu_rsp_valid, err_timeout}, 0);
      if (w == rsp_dly) begin mem_rsp_valid = 1'b1; mem_rdata = rd; end
      if (w == rsp_dly || w == TO - 1) break;
      @(negedge clk);
      w++;
    end

    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    timed = (rsp_dly > TO - 1);
    e_rd  = (timed || (exp_lsu && wen)) ? 32'd0 : rd;
    if (exp_lsu) lsu_rd_m = e_rd; else ifu_rd_m = e_rd;
    check_eq("rsp_ifu_v", ifu_rsp_valid, !exp_lsu);
    check_eq("rsp_lsu_v", lsu_rsp_valid, exp_lsu);
    check_eq("rsp_ifu_d", ifu_rdata, ifu_rd_m);
    check_eq("rsp_lsu_d", lsu_rdata, lsu_rd_m);
    check_eq("rsp_err", err_timeout, timed);
    check_eq("rsp_busy", busy, 0);
  endtask

  initial begin
    bit got;
    bit iv, lv;
    bit exp_l;

    repeat (3) begin
      @(negedge clk);
      ifu_req_valid = 1'($urandom_range(0, 1)); lsu_req_valid = 1'($urandom_range(0, 1));
      mem_rsp_valid = 1'($urandom_range(0, 1));
      #1;
      check_reset_outputs("rst");
    end
    @(negedge clk);
    rst = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_rsp_valid = 1'b0;
    #1;

    // Both requesters contending for four transactions from reset.
    for (int i = 0; i < 4; i++) begin
      do_txn(1, 1, 0, $urandom, $urandom, $urandom, 4'($urandom), $urandom, 0, 0, got);
`ifdef ARB_ROUND_ROBIN_EN
      exp_l = (i % 2 == 0);
`else
      exp_l = 1'b1;
`endif
      check_eq("contend_seq", got, exp_l);
    end

    do_txn(1, 0, 0, 32'h8000_0000, 0, 0, 0, 32'h0010_0073, 0, 0, got);
    check_eq("ifu_read_rdata", ifu_rdata, 32'h0010_0073);
    do_txn(0, 1, 1, 0, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, $urandom, 0, 0, got);
    do_txn(0, 1, 0, 0, $urandom, $urandom, 4'($urandom), $urandom, 5, 1, got);
    do_txn(1, 0, 0, $urandom, 0, 0, 0, $urandom, 0, 10, got);
    do_txn(0, 1, 0, 0, $urandom, 0, 4'($urandom), $urandom, 1, TO - 1, got);
    do_txn(1, 0, 0, $urandom, 0, 0, 0, $urandom, 2, TO, got);

    for (int k = 0; k < 40; k++) begin
      iv = 1'($urandom_range(0, 1));
      lv = iv ? 1'($urandom_range(0, 1)) : 1'b1;
      do_txn(iv, lv, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 4'($urandom),
             $urandom, $urandom_range(0, 3), $urandom_range(0, TO + 1), got);
    end

    // Reset during WAIT drops the transaction; a late memory response must be ignored.
    ifu_req_valid = 1'b1; ifu_addr = $urandom;
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #1;
    check_reset_outputs("wrst");
    @(negedge clk);
    rst = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    check_eq("post_rst_rspv", {ifu_rsp_valid, lsu_rsp_valid, err_timeout, busy}, 0);
    pref_lsu = 1'b1; ifu_rd_m = '0; lsu_rd_m = '0;
    do_txn(1, 1, 0, $urandom, $urandom, $urandom, 4'($urandom), $urandom, 0, 0, got);
    check_eq("post_rst_grant", got, 1);
    do_txn(1, 0, 0, $urandom, 0, 0, 0, $urandom, 1, 2, got);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
